// File: rtl/pc_branch_pkg.sv
// Shared types and helpers for the PC/branch sequencing stage.
package pc_branch_pkg;

    localparam int unsigned PC_STEP_DEF = 4;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    // Mask that clears the byte-offset bits below one instruction step.
    function automatic logic [63:0] align_mask(input int unsigned step);
        return ~(64'(step) - 64'd1);
    endfunction

endpackage

// File: rtl/pc_branch_unit_if.sv
// Fetch/execute handshake and ALU result bundle between the pipeline and the PC unit.
interface pc_branch_unit_if #(
    parameter int PC_WIDTH = 32
);
    logic                imem_req;
    logic                imem_ack;
    logic                ex_valid;
    logic                ex_ready;
    logic                is_branch;
    logic                uncond;
    logic                target_sel;
    logic [PC_WIDTH-1:0] offset;
    logic [PC_WIDTH-1:0] reg_target;
    logic                will_branch;
    logic                alu_cout;
    logic                carry_we;
    logic                halt;

    modport master (
        input  imem_req, ex_ready,
        output imem_ack, ex_valid, is_branch, uncond, target_sel, offset,
               reg_target, will_branch, alu_cout, carry_we, halt
    );

    modport slave (
        output imem_req, ex_ready,
        input  imem_ack, ex_valid, is_branch, uncond, target_sel, offset,
               reg_target, will_branch, alu_cout, carry_we, halt
    );
endinterface

// File: rtl/pc_branch_unit_next_sel.sv
// Next-PC datapath: sequential increment, branch target select, alignment and misalign detect.
module pc_next_sel
    import pc_branch_pkg::*;
#(
    parameter int          PC_WIDTH = 32,
    parameter int unsigned PC_STEP  = PC_STEP_DEF
) (
    input  logic [PC_WIDTH-1:0] i_pc,
    input  logic [PC_WIDTH-1:0] i_offset,
    input  logic [PC_WIDTH-1:0] i_reg_target,
    input  logic                i_target_sel,
    output logic [PC_WIDTH-1:0] o_seq_pc,
    output logic [PC_WIDTH-1:0] o_target_pc,
    output logic                o_misalign
);

    localparam logic [63:0] ALIGN_MASK = align_mask(PC_STEP);

    logic [PC_WIDTH-1:0] w_mask;
    logic [PC_WIDTH-1:0] w_raw_target;

    assign w_mask       = ALIGN_MASK[PC_WIDTH-1:0];
    assign w_raw_target = i_target_sel ? i_reg_target : (i_pc + i_offset);
    assign o_seq_pc     = i_pc + PC_WIDTH'(PC_STEP);
    assign o_target_pc  = w_raw_target & w_mask;
    assign o_misalign   = |(w_raw_target & ~w_mask);

endmodule

// File: rtl/pc_branch_unit.sv
// Execute-to-fetch sequencer: holds PC and carry flag, redirects on branches, counts retirements.
//
// state | meaning
// FETCH | imem_req high, waiting for imem_ack on the current pc
// EXEC  | ex_ready high, waiting for ex_valid to retire the instruction
// HALT  | halt retired; everything frozen until reset
module pc_branch_unit
    import pc_branch_pkg::*;
#(
    parameter int                PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter int unsigned       PC_STEP  = PC_STEP_DEF
) (
    input  logic                clk,
    input  logic                rst,
    pc_branch_unit_if.slave     bus,
    output logic [PC_WIDTH-1:0] o_pc,
    output logic [PC_WIDTH-1:0] o_link_pc,
    output logic                o_carry_flag,
    output logic                o_taken,
    output logic                o_misalign,
    output logic                o_halted,
    output logic [31:0]         o_retired
);

    state_t              r_state;
    state_t              w_state_next;
    logic [PC_WIDTH-1:0] r_pc;
    logic                r_carry;
    logic                r_taken;
    logic                r_misalign;
    logic                r_halted;
    logic [31:0]         r_retired;

    logic                w_imem_req;
    logic                w_ex_ready;
    logic                w_retire;
    logic                w_take;
    logic [PC_WIDTH-1:0] w_seq_pc;
    logic [PC_WIDTH-1:0] w_target_pc;
    logic                w_target_misalign;

    pc_next_sel #(
        .PC_WIDTH (PC_WIDTH),
        .PC_STEP  (PC_STEP)
    ) u_next_sel (
        .i_pc         (r_pc),
        .i_offset     (bus.offset),
        .i_reg_target (bus.reg_target),
        .i_target_sel (bus.target_sel),
        .o_seq_pc     (w_seq_pc),
        .o_target_pc  (w_target_pc),
        .o_misalign   (w_target_misalign)
    );

    // Halt outranks any branch retiring in the same instruction.
    assign w_take = bus.is_branch & (bus.uncond | bus.will_branch) & ~bus.halt;

    always_comb begin
        w_state_next = r_state;
        w_imem_req   = 1'b0;
        w_ex_ready   = 1'b0;
        w_retire     = 1'b0;
        case (r_state)
            FETCH: begin
                w_imem_req = 1'b1;
                if (bus.imem_ack) w_state_next = EXEC;
            end
            EXEC: begin
                w_ex_ready = 1'b1;
                if (bus.ex_valid) begin
                    w_retire     = 1'b1;
                    w_state_next = bus.halt ? HALT : FETCH;
                end
            end
            HALT: w_state_next = HALT;
            default: w_state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= FETCH;
            r_pc       <= RESET_PC;
            r_carry    <= 1'b0;
            r_taken    <= 1'b0;
            r_misalign <= 1'b0;
            r_halted   <= 1'b0;
            r_retired  <= 32'd0;
        end else begin
            r_state  <= w_state_next;
            r_halted <= (w_state_next == HALT);
            r_taken  <= 1'b0;
            if (w_retire) begin
                r_retired <= r_retired + 32'd1;
                if (bus.carry_we) r_carry <= bus.alu_cout;
                if (!bus.halt) begin
                    if (w_take) begin
                        r_pc    <= w_target_pc;
                        r_taken <= 1'b1;
                        if (w_target_misalign) r_misalign <= 1'b1;
                    end else begin
                        r_pc <= w_seq_pc;
                    end
                end
            end
        end
    end

    assign bus.imem_req = w_imem_req;
    assign bus.ex_ready = w_ex_ready;
    assign o_pc         = r_pc;
    assign o_link_pc    = w_seq_pc;
    assign o_carry_flag = r_carry;
    assign o_taken      = r_taken;
    assign o_misalign   = r_misalign;
    assign o_halted     = r_halted;
    assign o_retired    = r_retired;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Bench for pc_branch_unit: directed scenarios plus random traffic against a transaction-level model.
module tb_pc_branch_unit;

    localparam int W    = 32;
    localparam int STEP = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_branch_unit_if #(.PC_WIDTH(W)) bus();

    logic [W-1:0] o_pc, o_link_pc;
    logic         o_carry_flag, o_taken, o_misalign, o_halted;
    logic [31:0]  o_retired;

    pc_branch_unit #(.PC_WIDTH(W), .RESET_PC(32'h0), .PC_STEP(STEP)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .o_pc         (o_pc),
        .o_link_pc    (o_link_pc),
        .o_carry_flag (o_carry_flag),
        .o_taken      (o_taken),
        .o_misalign   (o_misalign),
        .o_halted     (o_halted),
        .o_retired    (o_retired)
    );

    int checks = 0;
    int errors = 0;

    // Model: "awaiting execute" / "halted" flags plus architectural values.
    logic [31:0] m_pc, m_retired;
    bit          m_exec, m_halted, m_carry, m_taken, m_mis;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic lit(input string name, input logic [31:0] dut_v, input logic [31:0] mdl_v,
                       input logic [31:0] exp);
        chk({name, "_dut"}, dut_v, exp);
        chk({name, "_model"}, mdl_v, exp);
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_retired = 0; m_exec = 0; m_halted = 0;
        m_carry = 0; m_taken = 0; m_mis = 0;
    endtask

    task automatic compare_all();
        chk("imem_req",   {31'd0, bus.imem_req}, {31'd0, !m_halted && !m_exec});
        chk("ex_ready",   {31'd0, bus.ex_ready}, {31'd0, !m_halted && m_exec});
        chk("pc",         o_pc, m_pc);
        chk("link_pc",    o_link_pc, m_pc + STEP);
        chk("carry_flag", {31'd0, o_carry_flag}, {31'd0, m_carry});
        chk("taken",      {31'd0, o_taken}, {31'd0, m_taken});
        chk("misalign",   {31'd0, o_misalign}, {31'd0, m_mis});
        chk("halted",     {31'd0, o_halted}, {31'd0, m_halted});
        chk("retired",    o_retired, m_retired);
    endtask

    // Advance the model by one clock from the currently applied inputs, then check the DUT.
    task automatic step();
        logic [31:0] n_pc, t;
        bit          n_exec, n_halted, n_carry, n_taken, n_mis;
        logic [31:0] n_ret;
        n_pc = m_pc; n_exec = m_exec; n_halted = m_halted; n_carry = m_carry;
        n_taken = 0; n_mis = m_mis; n_ret = m_retired;
        if (!m_halted) begin
            if (!m_exec) begin
                if (bus.imem_ack) n_exec = 1;
            end else if (bus.ex_valid) begin
                n_ret = m_retired + 1;
                if (bus.carry_we) n_carry = bus.alu_cout;
                if (bus.halt) begin
                    n_halted = 1;
                end else if (bus.is_branch && (bus.uncond || bus.will_branch)) begin
                    t = bus.target_sel ? bus.reg_target : m_pc + bus.offset;
                    if (t % STEP != 0) n_mis = 1;
                    n_pc = t - (t % STEP);
                    n_taken = 1;
                    n_exec = 0;
                end else begin
                    n_pc = m_pc + STEP;
                    n_exec = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        m_pc = n_pc; m_exec = n_exec; m_halted = n_halted; m_carry = n_carry;
        m_taken = n_taken; m_mis = n_mis; m_retired = n_ret;
        compare_all();
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        #1;
        rst = 1'b0;
    endtask

    task automatic clear_inputs();
        bus.imem_ack = 0; bus.ex_valid = 0; bus.is_branch = 0; bus.uncond = 0;
        bus.target_sel = 0; bus.offset = '0; bus.reg_target = '0; bus.will_branch = 0;
        bus.alu_cout = 0; bus.carry_we = 0; bus.halt = 0;
    endtask

    // One instruction with a wait cycle before both ack and ex_valid.
    task automatic instr(input bit br, input bit unc, input bit tsel, input bit wb,
                         input bit cwe, input bit co, input bit hlt,
                         input logic [31:0] off, input logic [31:0] rt);
        clear_inputs();
        bus.is_branch = br; bus.uncond = unc; bus.target_sel = tsel; bus.will_branch = wb;
        bus.carry_we = cwe; bus.alu_cout = co; bus.halt = hlt; bus.offset = off;
        bus.reg_target = rt;
        step();
        bus.imem_ack = 1; step();
        bus.imem_ack = 0; step();
        bus.ex_valid = 1; step();
        bus.ex_valid = 0;
    endtask

    initial begin
        logic [31:0] ret_before;
        clear_inputs();
        model_reset();
        #12;
        compare_all();
        rst = 1'b0;

        // Reset arriving while waiting in execute
        instr(0, 0, 0, 0, 1, 1, 0, 0, 0);
        lit("pre_reset_pc", o_pc, m_pc, 32'h4);
        bus.imem_ack = 1; step(); bus.imem_ack = 0;
        step();
        reset_pulse();
        lit("rst_pc", o_pc, m_pc, 32'h0);
        lit("rst_carry", {31'd0, o_carry_flag}, {31'd0, m_carry}, 32'h0);
        lit("rst_retired", o_retired, m_retired, 32'h0);
        lit("rst_imem_req", {31'd0, bus.imem_req}, {31'd0, !m_exec}, 32'h1);

        // Sequential instructions
        repeat (3) instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
        lit("seq_pc", o_pc, m_pc, 32'hC);
        lit("seq_retired", o_retired, m_retired, 32'd3);

        // Relative conditional branch taken and not taken
        instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
        lit("pc_at_10", o_pc, m_pc, 32'h10);
        instr(1, 0, 0, 1, 0, 0, 0, 32'hFFFF_FFF0, 0);
        lit("br_pc", o_pc, m_pc, 32'h0);
        lit("br_taken", {31'd0, o_taken}, {31'd0, m_taken}, 32'h1);
        step();
        lit("br_taken_drop", {31'd0, o_taken}, {31'd0, m_taken}, 32'h0);
        repeat (4) instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
        instr(1, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFF0, 0);
        lit("nt_pc", o_pc, m_pc, 32'h14);
        lit("nt_taken", {31'd0, o_taken}, {31'd0, m_taken}, 32'h0);

        // Misaligned register target, then aligned branch keeps it sticky
        instr(1, 0, 1, 1, 0, 0, 0, 0, 32'h0000_0106);
        lit("mis_pc", o_pc, m_pc, 32'h104);
        lit("mis_flag", {31'd0, o_misalign}, {31'd0, m_mis}, 32'h1);
        instr(1, 1, 1, 0, 0, 0, 0, 0, 32'h0000_0200);
        lit("mis_sticky", {31'd0, o_misalign}, {31'd0, m_mis}, 32'h1);

        // Carry retention and PC wrap
        instr(0, 0, 0, 0, 1, 1, 0, 0, 0);
        instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
        lit("carry_hold", {31'd0, o_carry_flag}, {31'd0, m_carry}, 32'h1);
        instr(1, 1, 1, 0, 0, 0, 0, 0, 32'hFFFF_FFFC);
        instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
        lit("wrap_pc", o_pc, m_pc, 32'h0);

        // Halt beats a simultaneous unconditional branch
        instr(1, 1, 1, 0, 1, 0, 0, 0, 32'h20);
        lit("pre_halt_carry", {31'd0, o_carry_flag}, {31'd0, m_carry}, 32'h0);
        ret_before = o_retired;
        instr(1, 1, 1, 0, 1, 1, 1, 0, 32'h400);
        lit("halt_flag", {31'd0, o_halted}, {31'd0, m_halted}, 32'h1);
        lit("halt_pc", o_pc, m_pc, 32'h20);
        lit("halt_taken", {31'd0, o_taken}, {31'd0, m_taken}, 32'h0);
        lit("halt_carry", {31'd0, o_carry_flag}, {31'd0, m_carry}, 32'h1);
        chk("halt_retired", o_retired, ret_before + 1);
        bus.imem_ack = 1; bus.ex_valid = 1; bus.uncond = 1;
        repeat (6) step();
        lit("halt_frozen_pc", o_pc, m_pc, 32'h20);
        chk("halt_frozen_retired", o_retired, ret_before + 1);
        reset_pulse();

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            if (m_halted && $urandom_range(0, 3) == 0) begin
                reset_pulse();
            end else begin
                bus.imem_ack    = ($urandom_range(0, 1) == 1);
                bus.ex_valid    = ($urandom_range(0, 1) == 1);
                bus.is_branch   = ($urandom_range(0, 4) < 2);
                bus.uncond      = ($urandom_range(0, 3) == 0);
                bus.target_sel  = ($urandom_range(0, 1) == 1);
                bus.will_branch = ($urandom_range(0, 1) == 1);
                bus.carry_we    = ($urandom_range(0, 1) == 1);
                bus.alu_cout    = ($urandom_range(0, 1) == 1);
                bus.halt        = ($urandom_range(0, 39) == 0);
                bus.offset      = ($urandom_range(0, 3) == 0) ? $urandom
                                  : 32'($signed($urandom_range(0, 512)) - 256);
                bus.reg_target  = $urandom;
                step();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
